serial_seq_tx: RTL and testbench

- Transmitter end of the FSM input-sequence interface: takes a parallel data word (e.g. a matricula number) and emits it as a timed stream of symbols on `a`.
- Its output drives the `a`/`res` inputs of the sequence-recognising state machines (behavioural, ROM-based and gate-level variants).
- Replaces hand-written `#1 a=...` stimulus lists with a synthesizable, handshaked serializer.
- Supports MSB- or LSB-first order, 1- or 2-bit symbols, and a programmable per-symbol hold time.

---
 rtl/serial_seq_tx.sv | 110 +++++++++++
 tb/tb_serial_seq_tx.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/serial_seq_tx.sv
// Serializer feeding the sequence-recognising FSMs. It latches a parallel word on start and
// emits it on `a` as SYM_W-bit symbols, each held for a programmable number of cycles.
module serial_seq_tx #(
   parameter int DATA_W = 17,
   parameter int SYM_W  = 1,
   parameter int HOLD_W = 4,
   parameter int CNT_W  = 5
) (
   input  logic              clk,
   input  logic              res,
   input  logic              start,
   input  logic [DATA_W-1:0] din,
   input  logic              msb_first,
   input  logic [HOLD_W-1:0] hold,
   output logic [SYM_W-1:0]  a,
   output logic              a_valid,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  sym_left
);

   localparam int NSYM = (DATA_W + SYM_W - 1) / SYM_W;
   localparam int PW   = NSYM * SYM_W;
   localparam int PAD  = PW - DATA_W;

   typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

   state_t            state, state_nxt;
   logic [PW-1:0]     sh_q, sh_nxt;
   logic              msb_q, msb_nxt;
   logic [HOLD_W-1:0] hlen_q, hlen_nxt;
   logic [HOLD_W-1:0] hcnt_q, hcnt_nxt;
   logic [CNT_W-1:0]  left_q, left_nxt;
   logic [PW-1:0]     ext;
   logic [HOLD_W-1:0] hold_eff;

   // Word padded to a whole number of symbols; for MSB-first the padding lands in the low bits.
   always_comb begin
      ext = '0;
      ext[DATA_W-1:0] = din;
      hold_eff = (hold == '0) ? HOLD_W'(1) : hold;
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state  <= IDLE;
         sh_q   <= '0;
         msb_q  <= 1'b0;
         hlen_q <= '0;
         hcnt_q <= '0;
         left_q <= '0;
      end else begin
         state  <= state_nxt;
         sh_q   <= sh_nxt;
         msb_q  <= msb_nxt;
         hlen_q <= hlen_nxt;
         hcnt_q <= hcnt_nxt;
         left_q <= left_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      sh_nxt    = sh_q;
      msb_nxt   = msb_q;
      hlen_nxt  = hlen_q;
      hcnt_nxt  = hcnt_q;
      left_nxt  = left_q;
      case (state)
         // DONE accepts start exactly like IDLE so frames can run back to back.
         IDLE, DONE: begin
            state_nxt = IDLE;
            left_nxt  = '0;
            if (start) begin
               sh_nxt    = msb_first ? (ext << PAD) : ext;
               msb_nxt   = msb_first;
               hlen_nxt  = hold_eff;
               hcnt_nxt  = hold_eff - HOLD_W'(1);
               left_nxt  = CNT_W'(NSYM);
               state_nxt = SEND;
            end
         end
         SEND: begin
            if (hcnt_q != '0) begin
               hcnt_nxt = hcnt_q - HOLD_W'(1);
            end else if (left_q > CNT_W'(1)) begin
               sh_nxt   = msb_q ? (sh_q << SYM_W) : (sh_q >> SYM_W);
               left_nxt = left_q - CNT_W'(1);
               hcnt_nxt = hlen_q - HOLD_W'(1);
            end else begin
               left_nxt  = '0;
               state_nxt = DONE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs decode only registered state, so the asynchronous reset clears them at once.
   always_comb begin
      a_valid  = (state == SEND);
      busy     = (state == SEND);
      done     = (state == DONE);
      sym_left = left_q;
      a        = '0;
      if (state == SEND)
         a = msb_q ? sh_q[PW-1 -: SYM_W] : sh_q[SYM_W-1:0];
   end

endmodule

// File: tb/tb_serial_seq_tx.sv
// Directed bench for serial_seq_tx: 1-bit and 2-bit symbol instances, checked on the falling edge.
module tb_serial_seq_tx;

   logic        clk = 1'b0;
   logic        res = 1'b1;
   logic        start1 = 1'b0, start2 = 1'b0;
   logic [16:0] din = '0;
   logic        msb_first = 1'b1;
   logic [3:0]  hold = 4'd1;

   logic       a1, av1, busy1, done1;
   logic [4:0] left1;
   logic [1:0] a2;
   logic       av2, busy2, done2;
   logic [3:0] left2;

   int checks = 0;
   int errors = 0;

   localparam logic [16:0] SEQ_MSB = 17'b10110100101111011;
   localparam logic [16:0] SEQ_LSB = 17'b11011110100101101;

   serial_seq_tx #(.DATA_W(17), .SYM_W(1), .HOLD_W(4), .CNT_W(5)) dut1 (
      .clk(clk), .res(res), .start(start1), .din(din), .msb_first(msb_first), .hold(hold),
      .a(a1), .a_valid(av1), .busy(busy1), .done(done1), .sym_left(left1));

   serial_seq_tx #(.DATA_W(17), .SYM_W(2), .HOLD_W(4), .CNT_W(4)) dut2 (
      .clk(clk), .res(res), .start(start2), .din(din), .msb_first(msb_first), .hold(hold),
      .a(a2), .a_valid(av2), .busy(busy2), .done(done2), .sym_left(left2));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle1(input string tag);
      chk({tag, "_a"},     32'(a1),    32'd0);
      chk({tag, "_valid"}, 32'(av1),   32'd0);
      chk({tag, "_busy"},  32'(busy1), 32'd0);
      chk({tag, "_done"},  32'(done1), 32'd0);
      chk({tag, "_left"},  32'(left1), 32'd0);
   endtask

   // Called at the falling edge where symbol 0 is visible; ends on the DONE cycle.
   task automatic check_frame1(input string tag, input logic [16:0] seq, input int h, input bit poke);
      for (int i = 0; i < 17; i++) begin
         for (int j = 0; j < h; j++) begin
            chk({tag, "_a"},     32'(a1),    32'(seq[16-i]));
            chk({tag, "_valid"}, 32'(av1),   32'd1);
            chk({tag, "_busy"},  32'(busy1), 32'd1);
            chk({tag, "_left"},  32'(left1), 32'(17 - i));
            if (poke && i == 3 && j == 1) begin
               start1 = 1'b1; din = '0; msb_first = 1'b0; hold = 4'd1;
            end
            if (poke && i == 4 && j == 0) start1 = 1'b0;
            @(negedge clk);
         end
      end
      chk({tag, "_done"},   32'(done1), 32'd1);
      chk({tag, "_done_a"}, 32'(a1),    32'd0);
      chk({tag, "_done_v"}, 32'(av1),   32'd0);
      chk({tag, "_done_b"}, 32'(busy1), 32'd0);
      chk({tag, "_done_l"}, 32'(left1), 32'd0);
   endtask

   initial begin
      int e2 [9] = '{2, 3, 1, 0, 2, 3, 3, 1, 2};

      #2 res = 1'b0;
      @(negedge clk);
      chk_idle1("rst");
      chk("rst_a2", 32'(av2), 32'd0);
      chk("rst_l2", 32'(left2), 32'd0);
      res = 1'b1;
      @(negedge clk);
      chk_idle1("post_rst");

      // 1: MSB first, hold 1
      din = 17'd92539; msb_first = 1'b1; hold = 4'd1; start1 = 1'b1;
      @(negedge clk); start1 = 1'b0;
      check_frame1("t1", SEQ_MSB, 1, 1'b0);
      @(negedge clk);
      chk_idle1("t1_after");

      // 2: LSB first, hold 0 behaves as 1
      msb_first = 1'b0; hold = 4'd0; start1 = 1'b1;
      @(negedge clk); start1 = 1'b0;
      check_frame1("t2", SEQ_LSB, 1, 1'b0);
      @(negedge clk);
      chk_idle1("t2_after");

      // 3: hold 3, start re-pulsed and inputs changed mid-frame
      din = 17'd92539; msb_first = 1'b1; hold = 4'd3; start1 = 1'b1;
      @(negedge clk); start1 = 1'b0;
      check_frame1("t3", SEQ_MSB, 3, 1'b1);
      @(negedge clk);
      chk_idle1("t3_after");

      // 4: 2-bit symbols, last one zero-padded
      din = 17'd92539; msb_first = 1'b1; hold = 4'd1; start2 = 1'b1;
      @(negedge clk); start2 = 1'b0;
      for (int k = 0; k < 9; k++) begin
         chk("t4_a",     32'(a2),    32'(e2[k]));
         chk("t4_valid", 32'(av2),   32'd1);
         chk("t4_left",  32'(left2), 32'(9 - k));
         @(negedge clk);
      end
      chk("t4_done",   32'(done2), 32'd1);
      chk("t4_done_a", 32'(a2),    32'd0);
      chk("t4_done_l", 32'(left2), 32'd0);
      @(negedge clk);
      chk("t4_idle", 32'(done2), 32'd0);

      // 5: asynchronous reset during the 5th symbol
      msb_first = 1'b0; start1 = 1'b1;
      @(negedge clk); start1 = 1'b0;
      repeat (4) @(negedge clk);
      chk("t5_pre_a",    32'(a1),    32'd1);
      chk("t5_pre_left", 32'(left1), 32'd13);
      #2 res = 1'b0;
      #1 chk_idle1("t5_async");
      repeat (3) begin
         @(negedge clk);
         chk_idle1("t5_held");
      end
      res = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk_idle1("t5_released");
      end

      // 6: back-to-back with start held through DONE; second frame LSB first
      msb_first = 1'b1; hold = 4'd1; start1 = 1'b1;
      @(negedge clk);
      check_frame1("t6a", SEQ_MSB, 1, 1'b0);
      msb_first = 1'b0;
      @(negedge clk); start1 = 1'b0;
      check_frame1("t6b", SEQ_LSB, 1, 1'b0);
      @(negedge clk);
      chk_idle1("t6_after");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
